traffic_phase_sequencer: RTL

- Parametrised successor to the fixed four-approach traffic light controller.
- Sequences N_PHASES signal phases through GREEN -> YELLOW -> ALL-RED, with programmable dwell times and a tick prescaler.
- Adds demand-based phase skipping, green hold, and emergency pre-emption.
- Sits at intersection top level; drives one 3-bit lamp group per phase.

---
 rtl/traffic_phase_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/traffic_phase_sequencer.sv
// Multi-phase traffic signal sequencer: GREEN -> YELLOW -> ALL-RED per phase,
// with demand skipping, green hold and emergency pre-emption.
//
//   state  | meaning
//   GREEN  | active phase green, timer runs unless hold
//   YELLOW | active phase yellow, clearance before all-red
//   ALLRED | every group red, picks next phase (or emergency) on expiry
//   EMERG  | emergency phase green while emg stays high
module traffic_phase_sequencer #(
  parameter int N_PHASES = 4,
  parameter int T_GREEN  = 7,
  parameter int T_YELLOW = 3,
  parameter int T_ALLRED = 2,
  parameter int TICK_DIV = 1,
  parameter int CNT_W    = 8,
  localparam int PH_W    = (N_PHASES > 2) ? $clog2(N_PHASES) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_PHASES-1:0]     req,
  input  logic                    skip_en,
  input  logic                    hold,
  input  logic                    emg,
  input  logic [PH_W-1:0]         emg_phase,
  output logic [3*N_PHASES-1:0]   lights,
  output logic [PH_W-1:0]         active_phase,
  output logic [1:0]              state
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PS_W-1:0]  PS_LAST = PS_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST = PH_W'(N_PHASES - 1);
  localparam logic [PH_W:0]    PH_NUM  = (PH_W + 1)'(N_PHASES);
  localparam logic [CNT_W-1:0] TG      = CNT_W'(T_GREEN);
  localparam logic [CNT_W-1:0] TY      = CNT_W'(T_YELLOW);
  localparam logic [CNT_W-1:0] TA      = CNT_W'(T_ALLRED);

  typedef enum logic [1:0] {
    S_GREEN  = 2'd0,
    S_YELLOW = 2'd1,
    S_ALLRED = 2'd2,
    S_EMERG  = 2'd3
  } state_t;

  state_t                  state_r, state_n;
  logic [PH_W-1:0]         phase_r, phase_n, next_phase, emg_sel, cand;
  logic [CNT_W-1:0]        timer_r, timer_n;
  logic [PS_W-1:0]         presc_r, presc_n;
  logic [3*N_PHASES-1:0]   lights_n;
  logic [2:0]              lamp_code;
  logic                    tick, expire, step, found;

  function automatic logic [PH_W-1:0] inc_phase(input logic [PH_W-1:0] p);
    return (p == PH_LAST) ? '0 : p + PH_W'(1);
  endfunction

  assign emg_sel = ({1'b0, emg_phase} >= PH_NUM) ? '0 : emg_phase;

  // Cyclic search starting after the active phase; the active phase itself is last.
  always_comb begin
    cand       = phase_r;
    found      = 1'b0;
    next_phase = inc_phase(phase_r);
    if (skip_en) begin
      for (int k = 0; k < N_PHASES; k++) begin
        cand = inc_phase(cand);
        if (!found && req[cand]) begin
          found      = 1'b1;
          next_phase = cand;
        end
      end
    end
  end

  always_comb begin
    state_n = state_r;
    phase_n = phase_r;
    timer_n = timer_r;
    presc_n = presc_r;
    step    = 1'b0;
    tick    = (presc_r == PS_LAST);
    expire  = tick && (timer_r == CNT_W'(1));
    case (state_r)
      S_GREEN: begin
        if (emg && (phase_r != emg_sel)) begin
          state_n = S_YELLOW;
          timer_n = TY;
          presc_n = '0;
        end else if (emg) begin
          state_n = S_EMERG;
          presc_n = '0;
        end else if (!hold) begin
          if (expire) begin
            state_n = S_YELLOW;
            timer_n = TY;
            presc_n = '0;
          end else begin
            step = 1'b1;
          end
        end
      end
      S_YELLOW: begin
        if (expire) begin
          state_n = S_ALLRED;
          timer_n = TA;
          presc_n = '0;
        end else begin
          step = 1'b1;
        end
      end
      S_ALLRED: begin
        if (expire) begin
          presc_n = '0;
          if (emg) begin
            state_n = S_EMERG;
            phase_n = emg_sel;
          end else begin
            state_n = S_GREEN;
            phase_n = next_phase;
            timer_n = TG;
          end
        end else begin
          step = 1'b1;
        end
      end
      default: begin
        if (!emg) begin
          state_n = S_YELLOW;
          timer_n = TY;
          presc_n = '0;
        end
      end
    endcase
    if (step) begin
      presc_n = tick ? '0 : presc_r + PS_W'(1);
      if (tick) timer_n = timer_r - CNT_W'(1);
    end
  end

  // Lamps are decoded from the next state so they register alongside it.
  always_comb begin
    lights_n = {N_PHASES{3'b100}};
    case (state_n)
      S_GREEN, S_EMERG: lamp_code = 3'b001;
      S_YELLOW:         lamp_code = 3'b010;
      default:          lamp_code = 3'b100;
    endcase
    for (int i = 0; i < N_PHASES; i++) begin
      if (phase_n == PH_W'(i)) lights_n[3*i +: 3] = lamp_code;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_ALLRED;
      phase_r <= PH_LAST;
      timer_r <= TA;
      presc_r <= '0;
      lights  <= {N_PHASES{3'b100}};
    end else begin
      state_r <= state_n;
      phase_r <= phase_n;
      timer_r <= timer_n;
      presc_r <= presc_n;
      lights  <= lights_n;
    end
  end

  assign state        = state_r;
  assign active_phase = phase_r;

endmodule
